// File: rtl/tl_frag_pkg.sv
// Shared types and helpers for the TileLink-UL A-channel fragment sequencer.
// Beats are fixed at 4 bytes, so masks are always 4 bits wide.
package tl_frag_pkg;

   localparam int BEAT_BYTES = 4;
   localparam int LG_BEAT    = 2;

   localparam int PKG_ADDR_W = 32;
   localparam int PKG_SRC_W  = 4;
   localparam int PKG_SIZE_W = 3;

   typedef enum logic {IDLE, FULL} state_e;

   typedef struct packed {
      logic [2:0]            opcode;
      logic [PKG_SIZE_W-1:0] size;
      logic [PKG_SRC_W-1:0]  source;
      logic [PKG_ADDR_W-1:0] address;
      logic [3:0]            mask;
   } a_req_t;

   // Number of 4-byte beats for a (clamped) log2 byte size.
   function automatic int unsigned nbeats_of(input int unsigned size);
      return (size > LG_BEAT) ? (32'd1 << (size - LG_BEAT)) : 32'd1;
   endfunction

endpackage

// File: rtl/tl_frag_repeater_reg.sv
// Single-entry capture register plus beat counter. The counter stops at the
// captured last index; the parent decides when to leave the FULL state.
module tl_frag_repeater_reg
   import tl_frag_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int SRC_W  = 4,
   parameter int SIZE_W = 3,
   parameter int IDX_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_i,
   input  logic              adv_i,
   input  logic [2:0]        opcode_i,
   input  logic [SIZE_W-1:0] size_i,
   input  logic [SRC_W-1:0]  source_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [3:0]        mask_i,
   input  logic [IDX_W-1:0]  last_idx_i,
   output logic [2:0]        opcode_o,
   output logic [SIZE_W-1:0] size_o,
   output logic [SRC_W-1:0]  source_o,
   output logic [ADDR_W-1:0] base_o,
   output logic [3:0]        mask_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              multi_o,
   output logic              last_o
);

   logic [2:0]        opcode_q;
   logic [SIZE_W-1:0] size_q;
   logic [SRC_W-1:0]  source_q;
   logic [ADDR_W-1:0] base_q;
   logic [3:0]        mask_q;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  last_idx_q;

   always_comb begin
      idx_d = idx_q;
      if (load_i)               idx_d = '0;
      else if (adv_i && !last_o) idx_d = idx_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         opcode_q   <= '0;
         size_q     <= '0;
         source_q   <= '0;
         base_q     <= '0;
         mask_q     <= '0;
         last_idx_q <= '0;
         idx_q      <= '0;
      end else begin
         idx_q <= idx_d;
         if (load_i) begin
            opcode_q   <= opcode_i;
            size_q     <= size_i;
            source_q   <= source_i;
            base_q     <= base_i;
            mask_q     <= mask_i;
            last_idx_q <= last_idx_i;
         end
      end
   end

   assign opcode_o = opcode_q;
   assign size_o   = size_q;
   assign source_o = source_q;
   assign base_o   = base_q;
   assign mask_o   = mask_q;
   assign idx_o    = idx_q;
   assign multi_o  = (last_idx_q != '0);
   assign last_o   = (idx_q == last_idx_q);

endmodule

// File: rtl/tl_a_fragment_sequencer.sv
// Repeater + beat sequencer: holds one A-channel request and replays it as
// consecutive 4-byte sub-requests. No bypass; first beat appears one cycle later.
module tl_a_fragment_sequencer
   import tl_frag_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int SRC_W    = 4,
   parameter int SIZE_W   = 3,
   parameter int MAX_SIZE = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_opcode,
   input  logic [SIZE_W-1:0] in_size,
   input  logic [SRC_W-1:0]  in_source,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [3:0]        in_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_opcode,
   output logic [SIZE_W-1:0] out_size,
   output logic [SRC_W-1:0]  out_source,
   output logic [ADDR_W-1:0] out_address,
   output logic [3:0]        out_mask,
   output logic              out_last,
   output logic              repeater_full,
   output logic              err_mask,
   output logic              err_size
);

   localparam int IDX_W = (MAX_SIZE > LG_BEAT + 1) ? MAX_SIZE - LG_BEAT : 1;

   state_e            state_q, state_d;
   logic              accept, fire;
   logic [SIZE_W-1:0] eff_size;
   logic [ADDR_W-1:0] in_base;
   logic [IDX_W-1:0]  in_last_idx;
   logic              err_mask_q, err_mask_d;
   logic              err_size_q, err_size_d;

   logic [SIZE_W-1:0] size_r;
   logic [ADDR_W-1:0] base_r;
   logic [3:0]        mask_r;
   logic [IDX_W-1:0]  idx_r;
   logic              multi_r;

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready;

   // Oversized requests are clamped and forwarded as MAX_SIZE bursts.
   assign eff_size    = (in_size > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE) : in_size;
   assign in_base     = (eff_size > SIZE_W'(LG_BEAT))
                        ? (in_address & ({ADDR_W{1'b1}} << eff_size)) : in_address;
   assign in_last_idx = IDX_W'(nbeats_of(32'(eff_size)) - 32'd1);

   tl_frag_repeater_reg #(
      .ADDR_W (ADDR_W),
      .SRC_W  (SRC_W),
      .SIZE_W (SIZE_W),
      .IDX_W  (IDX_W)
   ) u_rep (
      .clock      (clock),
      .reset      (reset),
      .load_i     (accept),
      .adv_i      (fire),
      .opcode_i   (in_opcode),
      .size_i     (eff_size),
      .source_i   (in_source),
      .base_i     (in_base),
      .mask_i     (in_mask),
      .last_idx_i (in_last_idx),
      .opcode_o   (out_opcode),
      .size_o     (size_r),
      .source_o   (out_source),
      .base_o     (base_r),
      .mask_o     (mask_r),
      .idx_o      (idx_r),
      .multi_o    (multi_r),
      .last_o     (out_last)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = FULL;
         FULL:    if (fire && out_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      repeater_full = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         FULL: begin
            out_valid     = 1'b1;
            repeater_full = 1'b1;
         end
         default: ;
      endcase
   end

   assign err_mask_d = err_mask_q | (accept & (in_last_idx != '0) & (in_mask != 4'hf));
   assign err_size_d = err_size_q | (accept & (in_size > SIZE_W'(MAX_SIZE)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_mask_q <= 1'b0;
         err_size_q <= 1'b0;
      end else begin
         err_mask_q <= err_mask_d;
         err_size_q <= err_size_d;
      end
   end

   assign err_mask    = err_mask_q;
   assign err_size    = err_size_q;
   assign out_size    = (size_r > SIZE_W'(LG_BEAT)) ? SIZE_W'(LG_BEAT) : size_r;
   assign out_address = base_r + ADDR_W'({idx_r, 2'b00});
   // Multi-beat bursts always emit full lanes, regardless of the captured mask.
   assign out_mask    = multi_r ? 4'hf : mask_r;

endmodule

// File: doc/tl_a_fragment_sequencer.md
Name: tl_a_fragment_sequencer

Overview:
- Single-entry repeater plus beat sequencer on a TileLink-UL A channel, placed between a wide-burst master port and a 4-byte-beat slave port.
- Accepts one request, holds it in the repeater register, and re-emits it as consecutive 4-byte sub-requests with incrementing address until the burst is complete.
- Enforces the repeater invariant: while the repeater holds a multi-beat request, the emitted mask is all ones (4'hf). Violations are flagged on sticky status outputs.

Parameters:
- ADDR_W, 32, address width in bits.
- SRC_W, 4, source ID width.
- SIZE_W, 3, log2 byte-size field width.
- MAX_SIZE, 6, largest legal log2 size (64 B = 16 beats).
- Beat width is fixed at 4 bytes, so masks are 4 bits wide.

Ports:
- clock, in, 1, sole clock; all state on the rising edge.
- reset, in, 1, asynchronous, active-high reset.
- in_valid, in, 1, upstream request valid.
- in_ready, out, 1, upstream request ready.
- in_opcode, in, 3, TL opcode; passed through unchanged.
- in_size, in, SIZE_W, log2 bytes of the request.
- in_source, in, SRC_W, source ID.
- in_address, in, ADDR_W, byte address.
- in_mask, in, 4, byte-lane mask.
- out_valid, out, 1, downstream sub-request valid.
- out_ready, in, 1, downstream ready.
- out_opcode, out, 3, captured opcode.
- out_size, out, SIZE_W, min(captured size, 2).
- out_source, out, SRC_W, captured source.
- out_address, out, ADDR_W, base address + 4*beat index.
- out_mask, out, 4, lane mask for the current beat.
- out_last, out, 1, high on the final beat of the burst.
- repeater_full, out, 1, high while the repeater register holds a request.
- err_mask, out, 1, sticky: a multi-beat request arrived with in_mask != 4'hf.
- err_size, out, 1, sticky: a request arrived with in_size > MAX_SIZE.

Behaviour:
- Reset is asynchronous and active-high. During reset the block enters IDLE and all of these are 0: out_valid, repeater_full, err_mask, err_size, beat index, and the captured fields. Reset asserted mid-burst drops the held request without completing it.
- States and signals:
  - IDLE: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1, repeater_full=1.
- IDLE -> FULL on in_valid & in_ready:
  - Capture opcode, source and mask.
  - eff_size = min(in_size, MAX_SIZE).
  - Base = in_address with the low eff_size bits cleared when eff_size > 2; otherwise base = in_address.
  - nbeats = 2^(eff_size-2) when eff_size > 2, else 1. The beat index is cleared.
- There is no bypass path. The first out_valid appears on the cycle after acceptance, so minimum latency is 1 cycle and throughput is 1 beat per cycle while out_ready is held high.
- In FULL, on each out_valid & out_ready:
  - If out_last is high, go to IDLE. in_ready rises on the next cycle; there is no same-cycle refill.
  - Otherwise increment the beat index.
- out_last = (index == nbeats-1).
- out_address = base + {index, 2'b00}, computed modulo 2^ADDR_W; wrap-around at the top of the address space is permitted and not flagged.
- out_mask:
  - 4'hf for every beat of a multi-beat request.
  - The captured mask for a single-beat request.
- Output fields stay stable while out_valid & !out_ready (TL stability rule).
- err_mask is set when a request is accepted with nbeats > 1 and in_mask != 4'hf. The request is still forwarded with 4'hf.
- err_size is set when a request is accepted with in_size > MAX_SIZE. The request is forwarded as a MAX_SIZE burst.
- Both error flags are sticky until reset.
- in_valid while FULL is ignored (it is back-pressured), and no state changes.
- Index width is MAX_SIZE-2 bits (4 bits at default). The counter cannot pass nbeats-1.

Decomposition:
- Package tl_frag_pkg holds:
  - BEAT_BYTES=4 and LG_BEAT=2.
  - typedef state_e {IDLE, FULL}.
  - The struct a_req_t {opcode, size, source, address, mask}.
  - Function nbeats_of(size).
- One natural sub-module: tl_frag_repeater_reg. It holds the capture register, the beat counter and out_last generation; the parent keeps the FSM, the error flags and the address/mask muxing.

Test Plan:
- Single beat: size=2, addr=0x1004, mask=4'h3, out_ready=1. Expect 1 beat on the next cycle with addr 0x1004, mask 4'h3, size 2, last=1, then in_ready=1 one cycle later.
- 16 B burst: size=4, addr=0x2008, mask=4'hf, out_ready=1. Expect 4 beats at 0x2000, 0x2004, 0x2008, 0x200C with mask 4'hf and last only on beat 4; no errors.
- Backpressure: size=3 burst with out_ready toggled 0,1,0,0,1. Expect 2 beats; outputs stable across the stall cycles; repeater_full deasserts after the second handshake.
- Mask violation: size=5, mask=4'h7. Expect err_mask=1 and 8 beats, all with mask 4'hf; err_mask still 1 after a later clean request.
- Oversize and wrap: size=7, addr=0xFFFFFFC0. Expect err_size=1, 16 beats from 0xFFFFFFC0 to 0xFFFFFFFC, no wrap fault.
- Reset mid-burst: assert reset during beat 2 of a size=4 burst. Expect out_valid=0 and repeater_full=0 immediately (asynchronous); after release, in_ready=1 and the next request starts at beat 0.
